// File: rtl/alu_share_arb_if.sv
// Request, ALU and result bus of alu_share_arb.
// req_lock exists only when ALU_ARB_LOCK_EN is defined.
interface alu_share_arb_if #(
  parameter int W    = 8,
  parameter int Ops  = 4,
  parameter int NREQ = 2,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0][Ops-1:0] req_op;
  logic [NREQ-1:0][W-1:0]   req_a;
  logic [NREQ-1:0][W-1:0]   req_b;
`ifdef ALU_ARB_LOCK_EN
  logic [NREQ-1:0]          req_lock;
`endif
  logic [Ops-1:0]           alu_op;
  logic [W-1:0]             alu_a;
  logic [W-1:0]             alu_b;
  logic [W-1:0]             alu_out;
  logic                     alu_cond;
  logic                     res_valid;
  logic                     res_ready;
  logic [W-1:0]             res_data;
  logic                     res_cond;
  logic [IDW-1:0]           res_id;

  modport slave (
`ifdef ALU_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_valid, req_op, req_a, req_b, alu_out, alu_cond, res_ready,
    output req_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_cond, res_id
  );

  modport master (
`ifdef ALU_ARB_LOCK_EN
    output req_lock,
`endif
    output req_valid, req_op, req_a, req_b, alu_out, alu_cond, res_ready,
    input  req_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_cond, res_id
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters, with a
// one-entry tagged result register. Optional ALU_ARB_LOCK_EN adds sticky ownership.
module alu_share_arb #(
  parameter int W    = 8,
  parameter int Ops  = 4,
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input logic           clk,
  input logic           reset,
  alu_share_arb_if.slave bus
);
  logic [IDW-1:0]  rr_ptr, win, rr_next, cand;
  logic [NREQ-1:0] elig;
  logic            found, can_accept, hs;
`ifdef ALU_ARB_LOCK_EN
  logic            locked, win_lock;
  logic [IDW-1:0]  lock_owner;
`endif

  // While locked only the owner is eligible, whatever rr_ptr says
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
`ifdef ALU_ARB_LOCK_EN
    assign elig[i] = bus.req_valid[i] & (!locked | (lock_owner == IDW'(i)));
`else
    assign elig[i] = bus.req_valid[i];
`endif
  end

  assign can_accept = !bus.res_valid | bus.res_ready;
  assign hs         = found & can_accept & !reset;
  assign rr_next    = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ({1'b0, rr_ptr} + (IDW+1)'(k) >= (IDW+1)'(NREQ))
             ? IDW'({1'b0, rr_ptr} + (IDW+1)'(k) - (IDW+1)'(NREQ))
             : rr_ptr + IDW'(k);
      for (int j = 0; j < NREQ; j++) begin
        if (!found && elig[j] && cand == IDW'(j)) begin
          found = 1'b1;
          win   = IDW'(j);
        end
      end
    end
  end

  // Operands go to the ALU whenever there is a winner, even if stalled
  always_comb begin
    bus.req_ready = '0;
    bus.alu_op    = '0;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
`ifdef ALU_ARB_LOCK_EN
    win_lock      = 1'b0;
`endif
    for (int j = 0; j < NREQ; j++) begin
      if (found && win == IDW'(j)) begin
        bus.req_ready[j] = hs;
        bus.alu_op       = bus.req_op[j];
        bus.alu_a        = bus.req_a[j];
        bus.alu_b        = bus.req_b[j];
`ifdef ALU_ARB_LOCK_EN
        win_lock         = bus.req_lock[j];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_cond  <= 1'b0;
      bus.res_id    <= '0;
      rr_ptr        <= '0;
`ifdef ALU_ARB_LOCK_EN
      locked        <= 1'b0;
      lock_owner    <= '0;
`endif
    end else if (hs) begin
      bus.res_valid <= 1'b1;
      bus.res_data  <= bus.alu_out;
      bus.res_cond  <= bus.alu_cond;
      bus.res_id    <= win;
      rr_ptr        <= rr_next;
`ifdef ALU_ARB_LOCK_EN
      // Only the owner can win while locked, so a grant without lock releases it
      if (win_lock) begin
        locked     <= 1'b1;
        lock_owner <= win;
      end else begin
        locked     <= 1'b0;
      end
`endif
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a small stub ALU; lock case only with ALU_ARB_LOCK_EN.
module tb_alu_share_arb;
  localparam int W = 8, Ops = 4, NREQ = 2, IDW = 2;
  localparam logic [Ops-1:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_SLT = 4'h3;

  logic clk = 1'b0;
  logic reset;
  int   n_run = 0, n_fail = 0;

  alu_share_arb_if #(.W(W), .Ops(Ops), .NREQ(NREQ), .IDW(IDW)) bus ();

  alu_share_arb #(.W(W), .Ops(Ops), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Stub ALU: cond is carry/borrow for ADD/SUB, the compare result for SLT
  always_comb begin
    bus.alu_out  = '0;
    bus.alu_cond = 1'b0;
    case (bus.alu_op)
      OP_ADD: {bus.alu_cond, bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      OP_SUB: {bus.alu_cond, bus.alu_out} = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      OP_SLT: begin
        bus.alu_out  = {7'b0, bus.alu_a < bus.alu_b};
        bus.alu_cond = bus.alu_a < bus.alu_b;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.res_ready = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_op[0] = OP_ADD; bus.req_a[0] = 8'h05; bus.req_b[0] = 8'h03;
    bus.req_op[1] = OP_SLT; bus.req_a[1] = 8'h02; bus.req_b[1] = 8'h07;
`ifdef ALU_ARB_LOCK_EN
    bus.req_lock  = 2'b00;
`endif

    // reset held two cycles with both requesters valid
    repeat (2) begin
      tick();
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_valid", 32'(bus.res_valid), 32'h0);
      chk("rst_data",  32'(bus.res_data),  32'h0);
      chk("rst_id",    32'(bus.res_id),    32'h0);
    end
    reset = 1'b0;
    #1;
    chk("first_grant", 32'(bus.req_ready), 32'h1);
    chk("alu_op0",     32'(bus.alu_op),    32'(OP_ADD));
    chk("alu_a0",      32'(bus.alu_a),     32'h05);

    // contention: grants alternate 0,1,0
    tick();
    chk("add_valid", 32'(bus.res_valid), 32'h1);
    chk("add_data",  32'(bus.res_data),  32'h08);
    chk("add_cond",  32'(bus.res_cond),  32'h0);
    chk("add_id",    32'(bus.res_id),    32'h0);
    chk("grant1",    32'(bus.req_ready), 32'h2);
    chk("alu_a1",    32'(bus.alu_a),     32'h02);
    tick();
    chk("slt_data",  32'(bus.res_data),  32'h01);
    chk("slt_cond",  32'(bus.res_cond),  32'h1);
    chk("slt_id",    32'(bus.res_id),    32'h1);
    chk("grant0b",   32'(bus.req_ready), 32'h1);
    tick();
    chk("add2_data", 32'(bus.res_data),  32'h08);
    chk("add2_id",   32'(bus.res_id),    32'h0);
    chk("grant1b",   32'(bus.req_ready), 32'h2);

    // backpressure for three cycles
    bus.res_ready = 1'b0;
    bus.req_op[1] = OP_SUB; bus.req_a[1] = 8'h10; bus.req_b[1] = 8'h01;
    #1;
    chk("bp_ready0", 32'(bus.req_ready), 32'h0);
    repeat (3) begin
      tick();
      chk("bp_ready", 32'(bus.req_ready), 32'h0);
      chk("bp_valid", 32'(bus.res_valid), 32'h1);
      chk("bp_data",  32'(bus.res_data),  32'h08);
      chk("bp_id",    32'(bus.res_id),    32'h0);
    end
    bus.res_ready = 1'b1;
    #1;
    chk("bp_rr_kept", 32'(bus.req_ready), 32'h2);
    chk("bp_alu_op",  32'(bus.alu_op),    32'(OP_SUB));
    tick();
    chk("sub_valid", 32'(bus.res_valid), 32'h1);
    chk("sub_data",  32'(bus.res_data),  32'h0F);
    chk("sub_cond",  32'(bus.res_cond),  32'h0);
    chk("sub_id",    32'(bus.res_id),    32'h1);

    // drain with no requests: ALU inputs zero, result drops
    bus.req_valid = 2'b00;
    #1;
    chk("idle_ready", 32'(bus.req_ready), 32'h0);
    chk("idle_op",    32'(bus.alu_op),    32'h0);
    chk("idle_a",     32'(bus.alu_a),     32'h0);
    tick();
    chk("drain_valid", 32'(bus.res_valid), 32'h0);

    // leave rr_ptr at 1 with a held result, then reset
    bus.req_valid = 2'b01;
    #1;
    chk("mr_grant", 32'(bus.req_ready), 32'h1);
    tick();
    chk("mr_data", 32'(bus.res_data), 32'h08);
    bus.req_valid = 2'b00;
    bus.res_ready = 1'b0;
    tick();
    chk("mr_hold", 32'(bus.res_valid), 32'h1);
    reset = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    chk("mr_rst_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("mr_valid", 32'(bus.res_valid), 32'h0);
    chk("mr_rdata", 32'(bus.res_data),  32'h0);
    reset = 1'b0;
    bus.res_ready = 1'b1;
    #1;
    chk("mr_rr_zero", 32'(bus.req_ready), 32'h1);

`ifdef ALU_ARB_LOCK_EN
    bus.req_lock = 2'b10;
    tick();
    chk("lk_pre_id", 32'(bus.res_id),    32'h0);
    chk("lk_grant",  32'(bus.req_ready), 32'h2);
    tick();
    chk("lk_set_id", 32'(bus.res_id),    32'h1);
    repeat (4) begin
      chk("lk_ready", 32'(bus.req_ready), 32'h2);
      tick();
      chk("lk_id", 32'(bus.res_id), 32'h1);
    end
    bus.req_lock = 2'b00;
    #1;
    chk("unlk_ready", 32'(bus.req_ready), 32'h2);
    tick();
    chk("unlk_id",   32'(bus.res_id),    32'h1);
    chk("unlk_next", 32'(bus.req_ready), 32'h1);
    tick();
    chk("unlk_id0",  32'(bus.res_id),    32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Arbitrates shared access to the single combinational 8-bit ALU between NREQ requesters (e.g. execute stage, branch-compare unit, address-increment unit).
- Each requester presents op/operands with a valid/ready handshake.
- The block selects one requester per cycle round-robin, drives the ALU inputs, and captures Out/Cond in a one-entry result register tagged with the requester ID.
- Sits between the control/datapath requesters and the ALU instance. The ALU stays outside this block; its ports are wired through.

Parameters:
- W, 8, datapath width (matches ALU W).
- Ops, 4, ALU opcode width (matches ALU Ops; encodings from Definitions package).
- NREQ, 2, number of requesters, 2..4.
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_op  in  NREQ*Ops  per-requester ALU opcode, packed, requester i at [i*Ops +: Ops].
- req_a  in  NREQ*W  per-requester InputA, packed.
- req_b  in  NREQ*W  per-requester InputB, packed.
- alu_op  out  Ops  to ALU OP.
- alu_a  out  W  to ALU InputA.
- alu_b  out  W  to ALU InputB.
- alu_out  in  W  from ALU Out.
- alu_cond  in  1  from ALU Cond.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  consumer accepts result.
- res_data  out  W  captured ALU Out.
- res_cond  out  1  captured ALU Cond.
- res_id  out  IDW  index of the requester that produced the result.
- req_lock  in  NREQ  only present with ALU_ARB_LOCK_EN; see below.

Behaviour:
- Reset (synchronous, Reset=1 at a rising Clk edge):
  - res_valid=0, res_data=0, res_cond=0, res_id=0, rr_ptr=0.
  - A pending result is discarded.
  - req_ready is 0 while Reset is high.
- can_accept = !res_valid | res_ready. The output register drains and refills in the same cycle, so full throughput is one op per cycle.
- Arbitration (combinational):
  - Search requesters starting at index rr_ptr and wrapping modulo NREQ.
  - The first with req_valid=1 wins.
  - req_ready[win] = can_accept; all other bits are 0.
  - With no valid request, req_ready=0.
- ALU drive:
  - alu_op/alu_a/alu_b = winner's req_op/req_a/req_b whenever a winner exists, even if !can_accept.
  - With no winner they are all 0. Opcode 0 must not be treated as a handshake.
- Handshake on requester i at a Clk edge when req_valid[i] & req_ready[i]:
  - res_data<=alu_out, res_cond<=alu_cond, res_id<=i, res_valid<=1.
  - rr_ptr<=(i+1) mod NREQ.
- Latency: result visible exactly 1 cycle after the request handshake.
- Result drain:
  - If res_valid & res_ready and no new handshake, then res_valid<=0.
  - If both occur in the same cycle, the new result overwrites and res_valid stays 1.
- Backpressure: while res_valid & !res_ready, all req_ready=0, the result register holds stable, and rr_ptr is unchanged.
- Requester obligation: hold req_op/a/b stable while valid and not ready. The block does not latch operands before the handshake.
- Fairness: any continuously valid requester is granted within NREQ handshakes.
- rr_ptr wraps from NREQ-1 to 0.
- No combinational path from res_ready to res_valid/res_data. The path res_ready to req_ready is permitted.
- Illegal opcodes are passed through unchanged; ALU output is captured as-is.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- Defined:
  - Adds the req_lock port and a lock_owner/locked register, both reset to 0.
  - A handshake by requester i with req_lock[i]=1 sets locked=1, lock_owner=i.
  - While locked, only lock_owner can win arbitration, regardless of rr_ptr.
  - A handshake by the owner with req_lock=0 clears locked and advances rr_ptr normally.
  - Reset clears the lock.
  - Used for multi-op sequences such as SUB then SEQ on the same operand.
- Undefined: the port and registers are absent; pure round-robin.

Test Plan:
- Reset: hold Reset 2 cycles with req_valid=2'b11 -> req_ready=0, res_valid=0, res_data=0; first cycle after release req 0 granted.
- Single op: req0 ADD a=8'h05 b=8'h03 -> next cycle res_valid=1, res_data=8'h08, res_cond=0, res_id=0.
- Contention: both requesters valid continuously, res_ready=1 -> grants alternate 0,1,0,1; req1 SLT 2,7 yields res_data=1, res_cond=1, res_id=1.
- Backpressure: res_ready=0 with result 8'h08 held 3 cycles -> req_ready=0, res_data stable, rr_ptr stable; on res_ready=1, new SUB 8'h10-8'h01 result 8'h0F appears next cycle with res_valid never dropping.
- Mid-operation reset: Reset during res_valid=1 with res_ready=0 -> next cycle res_valid=0, rr_ptr=0.
- Lock (ALU_ARB_LOCK_EN): req1 locks, both valid for 4 cycles -> 4 consecutive grants to 1; req1 drops lock -> next grant goes to 0.
